// File: rtl/cpu_parameters.sv
// Shared types and constants for the memory execute stage.
package cpu_parameters;

  localparam int xlen = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    LD_MISALIGN = 2'd0,
    ST_MISALIGN = 2'd1,
    LD_FAULT    = 2'd2,
    ST_FAULT    = 2'd3
  } lsu_cause_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Reserved size code 3 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobes/data shift, and load extract with sign/zero extension.
module lsu_lane_align
  import cpu_parameters::*;
#(
  parameter  int XLEN     = xlen,
  localparam int NB_LANES = XLEN / 8
) (
  input  logic [1:0]          st_off,
  input  logic [1:0]          st_size,
  input  logic [XLEN-1:0]     st_data,
  output logic [NB_LANES-1:0] strobe,
  output logic [XLEN-1:0]     wdata,
  input  logic [1:0]          ld_off,
  input  logic [1:0]          ld_size,
  input  logic                ld_uns,
  input  logic [XLEN-1:0]     rdata,
  output logic [XLEN-1:0]     ld_data
);

  logic [XLEN-1:0] shifted;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here first, unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    strobe = '1;
    case (st_size)
      BYTE:    strobe = NB_LANES'(1) << st_off;
      HALF:    strobe = NB_LANES'(3) << st_off;
      default: strobe = '1;
    endcase
    wdata = st_data << {st_off, 3'b000};
  end

  always_comb begin
    shifted = rdata >> {ld_off, 3'b000};
    case (ld_size)
      BYTE:    ld_data = ld_uns ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      HALF:    ld_data = ld_uns ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      default: ld_data = ld_uns ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: single-outstanding IDLE/REQ/WAIT/RESP sequencer toward data memory.
// Optional response watchdog enabled by defining MEM_LSU_TIMEOUT_EN.
module mem_lsu
  import cpu_parameters::*;
#(
  parameter  int XLEN           = xlen,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int NB_LANES       = XLEN / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_v,
  output logic                in_ready,
  input  logic                is_store,
  input  logic [1:0]          size,
  input  logic                uns,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  input  logic [XLEN-1:0]     imm,
  input  logic [4:0]          rd_i,
  output logic                mem_req_v,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_adr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [NB_LANES-1:0] mem_strobe,
  input  logic                mem_rsp_v,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_rsp_err,
  output logic                wb_v,
  input  logic                wb_ready,
  output logic [XLEN-1:0]     wb_result,
  output logic [4:0]          wb_rd,
  output logic                wb_exc,
  output logic [1:0]          wb_cause
);

  if (XLEN % 8 != 0 || XLEN < 32) begin : g_bad_xlen
    $error("mem_lsu: XLEN must be a multiple of 8 and at least 32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_lsu: TIMEOUT_CYCLES must be positive");
  end

  lsu_state_t state_q, state_d;

  logic [XLEN-1:0]     ea;
  logic                misaligned, timeout, resp_done, fault;
  logic [NB_LANES-1:0] strobe_d;
  logic [XLEN-1:0]     wdata_d, ld_data;

  logic [1:0] size_q, off_q;
  logic       uns_q;
  logic [4:0] rd_q;
  lsu_cause_t cause_q;

  assign ea         = rs1 + imm;
  assign misaligned = is_misaligned(size, ea[1:0]);
  assign resp_done  = (state_q == WAIT) && (mem_rsp_v || timeout);
  // A response arriving alongside the watchdog expiry still wins.
  assign fault      = mem_rsp_v ? mem_rsp_err : 1'b1;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .st_off  (ea[1:0]),
    .st_size (size),
    .st_data (rs2),
    .strobe  (strobe_d),
    .wdata   (wdata_d),
    .ld_off  (off_q),
    .ld_size (size_q),
    .ld_uns  (uns_q),
    .rdata   (mem_rdata),
    .ld_data (ld_data)
  );

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_v)          state_d = misaligned ? RESP : REQ;
      REQ:     if (mem_req_ready) state_d = WAIT;
      WAIT:    if (resp_done)     state_d = RESP;
      RESP:    if (wb_ready)      state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // NOTE: payload registers are reset too, since their values are visible on
  // output ports that must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      mem_strobe <= '0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      uns_q      <= 1'b0;
      rd_q       <= 5'd0;
    end else if (state_q == IDLE && in_v) begin
      mem_we     <= is_store;
      mem_adr    <= {ea[XLEN-1:2], 2'b00};
      mem_wdata  <= wdata_d;
      mem_strobe <= strobe_d;
      size_q     <= size;
      off_q      <= ea[1:0];
      uns_q      <= uns;
      rd_q       <= rd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_exc    <= 1'b0;
      cause_q   <= LD_MISALIGN;
      wb_result <= '0;
      wb_rd     <= 5'd0;
    end else if (state_q == IDLE && in_v && misaligned) begin
      wb_exc    <= 1'b1;
      cause_q   <= is_store ? ST_MISALIGN : LD_MISALIGN;
      wb_result <= '0;
      wb_rd     <= 5'd0;
    end else if (resp_done) begin
      wb_exc    <= fault;
      cause_q   <= !fault ? LD_MISALIGN : (mem_we ? ST_FAULT : LD_FAULT);
      wb_result <= (fault || mem_we) ? '0 : ld_data;
      wb_rd     <= (fault || mem_we) ? 5'd0 : rd_q;
    end
  end

`ifdef MEM_LSU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  assign timeout = (state_q == WAIT) && !mem_rsp_v && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            tmo_cnt_q <= '0;
    else if (state_q == WAIT && !mem_rsp_v && !timeout)    tmo_cnt_q <= tmo_cnt_q + 1'b1;
    else                                                   tmo_cnt_q <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign mem_req_v = (state_q == REQ);
  assign wb_v      = (state_q == RESP);
  assign wb_cause  = cause_q;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised load/store unit; the next generation of the memory execute stage.
- Sits between the register manager (issue) and the write-back stage, with a valid/ready request/response port toward the data memory.
- Generalised over XLEN-wide data and byte lanes. Adds misalignment detection, a per-size sign/zero-extension mode, and backpressure-safe single-outstanding sequencing with a 4-state FSM.

Parameters:
- XLEN, 32, data/address width; must be a multiple of 8 and at least 32.
- NB_LANES, XLEN/8, byte lanes on the memory bus (derived; do not override).
- TIMEOUT_CYCLES, 64, response watchdog limit; used only with MEM_LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_v  in  1  issue valid
- in_ready  out  1  issue accept; transfer when in_v && in_ready
- is_store  in  1  1 = store, 0 = load
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- uns  in  1  zero-extend load (LBU/LHU)
- rs1  in  XLEN  base
- rs2  in  XLEN  store data
- imm  in  XLEN  offset
- rd_i  in  5  destination
- mem_req_v  out  1  request valid
- mem_req_ready  in  1  memory accept
- mem_we  out  1  write enable
- mem_adr  out  XLEN  word-aligned address (low 2 bits zero)
- mem_wdata  out  XLEN  lane-shifted store data
- mem_strobe  out  NB_LANES  byte enables
- mem_rsp_v  in  1  response valid (single-cycle pulse)
- mem_rdata  in  XLEN  full read word
- mem_rsp_err  in  1  bus error, qualified by mem_rsp_v
- wb_v  out  1  result valid
- wb_ready  in  1  write-back accept
- wb_result  out  XLEN  extended load data; 0 for stores/exceptions
- wb_rd  out  5  destination; 0 for stores/exceptions
- wb_exc  out  1  exception flag
- wb_cause  out  2  0 = load misaligned, 1 = store misaligned, 2 = load fault, 3 = store fault

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: FSM in IDLE; in_ready=1; mem_req_v=0; wb_v=0; wb_exc=0; all data outputs 0.
- FSM states:
  - IDLE: in_ready=1. On issue:
    - Compute ea = rs1+imm modulo 2^XLEN.
    - Misaligned means half with ea[0]=1, or word with ea[1:0]≠0. If misaligned, go to RESP with wb_exc=1 and cause 0 or 1; no memory request is issued.
    - Otherwise register the payload and go to REQ.
  - REQ: mem_req_v=1, payload stable until mem_req_ready. Then go to WAIT.
  - WAIT: on mem_rsp_v, capture the response and go to RESP.
    - Error response: wb_exc=1, cause 2 or 3.
    - Load: extract the lane selected by ea[1:0] and size, then sign-extend unless uns=1.
  - RESP: wb_v=1 and held stable until wb_ready. Then go to IDLE.
- Latency:
  - Issue → mem_req_v: 1 cycle.
  - mem_rsp_v → wb_v: 1 cycle.
  - Misaligned issue → wb_v: 1 cycle.
- in_ready is 1 only in IDLE. At most one outstanding request.
- Strobes: byte = 1<<ea[1:0]; half = 2'b11<<ea[1:0]; word = all ones.
- Store data: mem_wdata = rs2 shifted left by 8*ea[1:0].
- Stores produce wb_v with rd=0 and result=0, so the pipeline can retire them.
- mem_rsp_v outside WAIT is ignored; the bench asserts it never occurs.
- Simultaneous wb_ready and the next issue: accepted on the following cycle, since IDLE is re-entered first. There is no bypass.
- rst_n asserted mid-operation returns to IDLE immediately; any in-flight memory response is dropped.

Optional Feature:
- Macro: MEM_LSU_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without mem_rsp_v, the FSM goes to RESP with a fault cause (2 or 3) and the counter clears. A late response is then ignored.
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- cpu_parameters holds xlen, lsu_size_t (BYTE/HALF/WORD), lsu_cause_t, and lsu_state_t (IDLE/REQ/WAIT/RESP).
- One combinational sub-module, lsu_lane_align, provides:
  - strobe and store-data shift from (ea[1:0], size);
  - load extract and sign/zero extension from (rdata, ea[1:0], size, uns).
- The FSM, payload registers and watchdog stay in mem_lsu.

Test Plan:
- Load byte, signed: rs1=0x100, imm=3, rdata=0x80FF_0000, uns=0 → strobe 4'b1000, mem_adr=0x100, wb_result=0xFFFF_FF80.
- Load half, unsigned: ea=0x202, rdata=0xBEEF_1234, uns=1 → strobe 4'b1100, wb_result=0x0000_BEEF.
- Store word misaligned: ea=0x301 → no mem_req_v; wb_v next cycle with wb_exc=1, cause=1, wb_rd=0.
- Backpressure: mem_req_ready low for 3 cycles, then wb_ready low for 2 cycles → payload and wb outputs held stable; in_ready=0 throughout.
- Bus error on a load word: rsp_err=1 → wb_exc=1, cause=2, result=0. With MEM_LSU_TIMEOUT_EN and no response for 64 cycles → same cause.
- Reset asserted in WAIT, then a response arrives → wb_v stays 0 and the FSM is in IDLE after reset.
